// File: rtl/adler32_pkg.sv
// Shared constants for the streaming Adler-32 engine.
package adler32_pkg;

  localparam int DATA_WD   = 32;
  localparam int NUM_WD    = 2;
  localparam int NUM_BYTES = DATA_WD / 8;
  localparam int SUM_WD    = 19;

  localparam logic [15:0] ADLER_MOD = 16'd65521;
  localparam logic [15:0] A_INIT    = 16'd1;
  localparam logic [15:0] B_INIT    = 16'd0;

endpackage

// File: rtl/adler32_mod_reduce.sv
// Combinational modulo-65521 reduction of a 19-bit sum.
// Input must be below 8*65521; uses compare/subtract of 4M, 2M, then M.
module adler32_mod_reduce
  import adler32_pkg::*;
(
  input  logic [18:0] sum_i,
  output logic [15:0] res_o
);

  localparam logic [18:0] MOD_X4 = 19'd262084;
  localparam logic [18:0] MOD_X2 = 19'd131042;
  localparam logic [18:0] MOD_X1 = 19'd65521;

  logic [18:0] s4_s;
  logic [18:0] s2_s;

  // Subtract chain; the last step is done in 16 bits since the result is known to fit.
  always_comb begin
    s4_s  = sum_i;
    s2_s  = sum_i;
    res_o = 16'd0;
    if (sum_i >= MOD_X4) begin
      s4_s = sum_i - MOD_X4;
    end else begin
      s4_s = sum_i;
    end
    if (s4_s >= MOD_X2) begin
      s2_s = s4_s - MOD_X2;
    end else begin
      s2_s = s4_s;
    end
    if (s2_s >= MOD_X1) begin
      res_o = s2_s[15:0] - ADLER_MOD;
    end else begin
      res_o = s2_s[15:0];
    end
  end

endmodule

// File: rtl/adler32.sv
// Streaming Adler-32 checksum, up to 4 bytes per clock, one word per cycle.
// Optional macro ADLER32_OUT_REG_EN adds one more output register stage.
module adler32
  import adler32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 val_i,
  input  logic [DATA_WD-1:0]   dat_i,
  input  logic [NUM_WD-1:0]    num_i,
  input  logic                 lst_i,
  output logic                 done_o,
  output logic                 val_o,
  output logic [DATA_WD-1:0]   dat_o
);

  logic [15:0]        a_q, a_d, b_q, b_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic               val_q, val_d, done_q, done_d;

  logic [15:0]        base_a_s, base_b_s;
  logic [3:0]         lane_en_s;
  logic [18:0]        nxa_s;
  logic [2:0]         n_s;
  logic [2:0]         weight_s [NUM_BYTES];
  logic [7:0]         byte_s   [NUM_BYTES];
  logic [18:0]        sum_a_s, sum_b_s;
  logic [15:0]        a_red_s, b_red_s;

  // Raw sums for one word; start restarts from the initial values in the same cycle.
  always_comb begin
    base_a_s  = start_i ? A_INIT : a_q;
    base_b_s  = start_i ? B_INIT : b_q;
    n_s       = {1'b0, num_i} + 3'd1;
    lane_en_s = 4'b0001;
    nxa_s     = {3'b000, base_a_s};
    case (num_i)
      2'd0: begin
        lane_en_s = 4'b0001;
        nxa_s     = {3'b000, base_a_s};
      end
      2'd1: begin
        lane_en_s = 4'b0011;
        nxa_s     = {2'b00, base_a_s, 1'b0};
      end
      2'd2: begin
        lane_en_s = 4'b0111;
        nxa_s     = {3'b000, base_a_s} + {2'b00, base_a_s, 1'b0};
      end
      2'd3: begin
        lane_en_s = 4'b1111;
        nxa_s     = {1'b0, base_a_s, 2'b00};
      end
      default: begin
        lane_en_s = 4'b0001;
        nxa_s     = {3'b000, base_a_s};
      end
    endcase
    sum_a_s = {3'b000, base_a_s};
    sum_b_s = {3'b000, base_b_s} + nxa_s;
    for (int k = 0; k < NUM_BYTES; k++) begin
      // Lane k is the k-th byte of the stream, MSB lane first; it weighs (n-k) in B.
      if (lane_en_s[k]) begin
        byte_s[k]   = dat_i[8*(NUM_BYTES-1-k) +: 8];
        weight_s[k] = n_s - 3'(k);
      end else begin
        byte_s[k]   = 8'd0;
        weight_s[k] = 3'd0;
      end
      sum_a_s = sum_a_s + {11'd0, byte_s[k]};
      sum_b_s = sum_b_s + (19'(byte_s[k]) * 19'(weight_s[k]));
    end
  end

  adler32_mod_reduce u_red_a (
    .sum_i (sum_a_s),
    .res_o (a_red_s)
  );

  adler32_mod_reduce u_red_b (
    .sum_i (sum_b_s),
    .res_o (b_red_s)
  );

  // Next-state: absorb a valid word, else honour a bare start, else hold.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    dat_d  = dat_q;
    val_d  = 1'b0;
    done_d = 1'b0;
    if (val_i) begin
      a_d    = a_red_s;
      b_d    = b_red_s;
      dat_d  = {b_red_s, a_red_s};
      val_d  = 1'b1;
      done_d = lst_i;
    end else if (start_i) begin
      a_d = A_INIT;
      b_d = B_INIT;
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
  end

  // Checksum state and first output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q    <= A_INIT;
      b_q    <= B_INIT;
      dat_q  <= {B_INIT, A_INIT};
      val_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      dat_q  <= dat_d;
      val_q  <= val_d;
      done_q <= done_d;
    end
  end

`ifdef ADLER32_OUT_REG_EN
  logic [DATA_WD-1:0] dat2_q;
  logic               val2_q, done2_q;

  // Extra output stage: one more cycle of latency, same throughput.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat2_q  <= {B_INIT, A_INIT};
      val2_q  <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      dat2_q  <= dat_q;
      val2_q  <= val_q;
      done2_q <= done_q;
    end
  end

  assign dat_o  = dat2_q;
  assign val_o  = val2_q;
  assign done_o = done2_q;
`else
  assign dat_o  = dat_q;
  assign val_o  = val_q;
  assign done_o = done_q;
`endif

endmodule

// File: tb/tb_adler32.sv
// Self-checking bench for adler32: vector table plus scoreboard queue.
module tb_adler32;

  logic        clk;
  logic        rstn;
  logic        start_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic [1:0]  num_i;
  logic        lst_i;
  logic        done_o;
  logic        val_o;
  logic [31:0] dat_o;

  adler32 dut (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .num_i   (num_i),
    .lst_i   (lst_i),
    .done_o  (done_o),
    .val_o   (val_o),
    .dat_o   (dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        done;
    logic        burst;
  } exp_t;

  typedef struct {
    logic        start;
    logic [31:0] dat;
    logic [1:0]  num;
    logic        lst;
    logic [31:0] exp;
    int          gap;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_burst = 0;
  int first_burst_cyc = -1;
  int last_burst_cyc  = -1;

  // Byte-serial reference: A += d; B += A for each valid byte.
  function automatic logic [31:0] adler_ref(input logic [31:0] st, input logic [31:0] d,
                                            input logic [1:0] n);
    int a;
    int b;
    a = int'(st[15:0]);
    b = int'(st[31:16]);
    for (int k = 0; k <= int'(n); k++) begin
      a = (a + int'(d[8*(3-k) +: 8])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop one expectation per val_o pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (val_o) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_val_o: got val_o=1 dat_o=%08h, required no pulse", dat_o);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (dat_o !== e.dat) begin
            errors++;
            $display("FAIL dat_o: got %08h, required %08h", dat_o, e.dat);
          end
          checks++;
          if (done_o !== e.done) begin
            errors++;
            $display("FAIL done_o: got %0b, required %0b", done_o, e.done);
          end
          checks++;
          if (dat_o[15:0] >= 16'd65521 || dat_o[31:16] >= 16'd65521) begin
            errors++;
            $display("FAIL range: got %08h, required both halves below 65521", dat_o);
          end
          if (e.burst) begin
            if (first_burst_cyc < 0) first_burst_cyc = cyc;
            last_burst_cyc = cyc;
            n_burst++;
          end
        end
      end else begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++;
          $display("FAIL done_without_val: got done_o=%0b, required 0", done_o);
        end
      end
    end
  end

  task automatic drive(input logic st, input logic [31:0] d, input logic [1:0] n,
                       input logic l, input logic [31:0] e, input logic b);
    exp_t x;
    @(posedge clk); #1;
    start_i = st; val_i = 1'b1; dat_i = d; num_i = n; lst_i = l;
    x.dat = e; x.done = l; x.burst = b;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0; val_i = 1'b0;
      dat_i = $urandom; num_i = 2'($urandom_range(3, 0)); lst_i = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending outputs, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] d, input logic v);
    checks++;
    if (dat_o !== d || val_o !== v || done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got dat_o=%08h val_o=%0b done_o=%0b, required dat_o=%08h val_o=%0b done_o=0",
               name, dat_o, val_o, done_o, d, v);
    end
  endtask

  initial begin
    logic [31:0] model;
    start_i = 1'b0; val_i = 1'b0; dat_i = 32'h0; num_i = 2'd0; lst_i = 1'b0;
    rstn = 1'b0;

    vecs[0] = '{1'b1, 32'h6162_6300, 2'd2, 1'b1, 32'h024D_0127, 3};
    vecs[1] = '{1'b1, 32'h5769_6B69, 2'd3, 1'b0, 32'h03DA_0195, 10};
    vecs[2] = '{1'b0, 32'h7065_6469, 2'd3, 1'b0, 32'h0E4E_0337, 10};
    vecs[3] = '{1'b0, 32'h6100_0000, 2'd0, 1'b1, 32'h11E6_0398, 10};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 2'd3, 1'b1, 32'h09FA_03FD, 3};
    vecs[5] = '{1'b1, 32'h6162_63FF, 2'd2, 1'b1, 32'h024D_0127, 3};
    vecs[6] = '{1'b0, 32'h61A5_C3FF, 2'd0, 1'b0, 32'h03D5_0188, 3};
    vecs[7] = '{1'b1, 32'h5769_6B69, 2'd3, 1'b0, 32'h03DA_0195, 0};
    vecs[8] = '{1'b1, 32'h6162_6300, 2'd2, 1'b1, 32'h024D_0127, 3};

    #7;
    check_out("reset_state", 32'h0000_0001, 1'b0);
    @(negedge clk); rstn = 1'b1;

    // Bare start with no data.
    @(posedge clk); #1; start_i = 1'b1;
    idle(3);
    check_out("start_no_data", 32'h0000_0001, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].start, vecs[i].dat, vecs[i].num, vecs[i].lst, vecs[i].exp, 1'b0);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    idle(1);
    drain("table");

    // Bare start mid-stream, then data without start.
    drive(1'b1, 32'h5769_6B69, 2'd3, 1'b0, 32'h03DA_0195, 1'b0);
    @(posedge clk); #1; start_i = 1'b1; val_i = 1'b0;
    idle(3);
    drain("pre_start");
    check_out("start_holds_dat", 32'h03DA_0195, 1'b0);
    drive(1'b0, 32'h6162_6300, 2'd2, 1'b1, 32'h024D_0127, 1'b0);
    idle(3);
    drain("after_start");

    // Reset mid-stream drops the pending pulse and restarts the sums.
    drive(1'b1, 32'h5769_6B69, 2'd3, 1'b0, 32'h03DA_0195, 1'b0);
    @(posedge clk); #2;
    val_i = 1'b0; start_i = 1'b0;
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check_out("reset_mid_stream", 32'h0000_0001, 1'b0);
    @(negedge clk); rstn = 1'b1;
    idle(2);
    check_out("after_reset", 32'h0000_0001, 1'b0);
    drive(1'b0, 32'h6162_6300, 2'd2, 1'b1, 32'h024D_0127, 1'b0);
    idle(3);
    drain("after_reset");

    // Long back-to-back burst exercising modulo wrap.
    model = 32'h0000_0001;
    for (int i = 0; i < 20000; i++) begin
      model = adler_ref(model, 32'hFFFF_FFFF, 2'd3);
      drive(i == 0, 32'hFFFF_FFFF, 2'd3, i == 19999, model, 1'b1);
    end
    idle(1);
    drain("burst");
    checks++;
    if (n_burst != 20000 || (last_burst_cyc - first_burst_cyc) != 19999) begin
      errors++;
      $display("FAIL burst_throughput: got %0d pulses over %0d cycles, required 20000 over 19999",
               n_burst, last_burst_cyc - first_burst_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
